string_display: RTL and testbench
=================================

STRING_DISPLAY -- requirements
Module: string_display

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 1000, meaning clock cycles per digit slot (minimum 2).
REQ-002 The module SHALL have parameter BLINK_DIV, default 25_000_000, meaning clock cycles per cursor blink half-period (minimum 2).
REQ-003 The module SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port string, input, 32 bits: eight 4-bit character codes; digit k uses string[4k+3:4k].
REQ-006 The module SHALL have port count_8, input, 5 bits: cursor position within the window; 0..7 are valid.
REQ-007 The module SHALL have port mode, input, 4 bits: 0 means run (no cursor), nonzero means edit.
REQ-008 The module SHALL have port an, output, 8 bits: active-low digit enables; an[0] is the rightmost digit.
REQ-009 The module SHALL have port seg, output, 8 bits: active-low segments; seg[6:0] = g..a, seg[7] = dp.

Function
REQ-010 The block SHALL contain a prescaler d (0..SCAN_DIV-1) and a digit index idx (0..7).
- d increments every cycle.
- At d==SCAN_DIV-1: d becomes 0 and idx advances, wrapping 7 to 0.
REQ-011 Guard cycle: in the cycle where d==SCAN_DIV-1, an and seg SHALL be registered as 8'hFF (all off), to prevent ghosting.
REQ-012 In every other cycle, an SHALL be registered as all-ones except bit idx, which is low; exactly one bit is low.
REQ-013 Frame snapshot: at d==SCAN_DIV-1 with idx==7, string, count_8 and mode SHALL be latched into shadow registers.
- All digit decoding SHALL use the shadow registers only, so a frame never tears.
REQ-014 Glyph decode SHALL map code 0..F to the standard hex 7-segment glyphs 0-9, A, b, C, d, E, F.
REQ-015 seg and an SHALL be registered outputs, with 1 cycle of latency from the d/idx state.
REQ-016 The blink counter SHALL count 0..BLINK_DIV-1.
- Phase bit ph toggles at wrap.
- ph=1 means cursor visible.
REQ-017 Cursor digit: when shadow mode!=0, shadow count_8<=7 and idx==shadow count_8:
- ph=1: glyph shown with dp lit (seg[7]=0).
- ph=0: seg[6:0]=7'h7F (blanked) and dp lit.
REQ-018 Every non-cursor digit, and every digit when shadow mode==0, SHALL show its glyph with dp off (seg[7]=1).
REQ-019 Shadow count_8 in 8..31 SHALL produce no cursor on any digit; this is not an error.
REQ-020 The blink counter SHALL clear to 0 with ph=1 in the cycle after either of these changes is detected:
- the live count_8 changes; or
- the live mode goes from 0 to nonzero.
This makes the cursor visible immediately after a move.
REQ-021 If a blink wrap and a restart (REQ-020) occur in the same cycle, the restart SHALL win.
REQ-022 Arithmetic: d and the blink counter SHALL be sized with clog2 of their parameters; idx SHALL be 3 bits with natural wrap.

Reset
REQ-023 When reset=1 at a clock edge, the block SHALL set:
- d=0, idx=0, blink counter=0, ph=1;
- shadow string=0, shadow count_8=0, shadow mode=0;
- an=8'hFF, seg=8'hFF.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; the first digit after release SHALL be idx 0.
REQ-025 With reset low, an SHALL show digit 0 active (8'hFE) starting 1 cycle after release.

Verification
REQ-026 With SCAN_DIV=4, BLINK_DIV=16, string=32'h76543210, mode=0:
- an cycles FE,FE,FE,FF,FD,FD,FD,FF, ... through 7F.
- seg shows the glyphs 0..7 with dp off.
REQ-027 Change string from 32'h76543210 to 32'hFFFFFFFF while idx==3:
- digits 3..7 still show the old values;
- the new value appears from the next idx 0.
REQ-028 With mode=1 and count_8=2:
- digit 2 alternates between its glyph and blank every 16 cycles;
- dp stays lit on digit 2 only.
REQ-029 Change count_8 from 2 to 5 during a blank phase:
- the blink counter restarts;
- digit 5 is visible with dp in the first frame after the snapshot.
REQ-030 With mode=1 and count_8=9:
- no dp is lit;
- no digit blinks.
REQ-031 Assert reset for 1 cycle at idx=5, d=2:
- next cycle an=FF, seg=FF;
- then an=FE with the glyph of string nibble 0 as 0 (shadow cleared) until the first snapshot.

Source files
------------

// File: rtl/string_display.sv
// string_display: eight-digit multiplexed 7-segment driver with an edit cursor.
// A scan prescaler walks the digits; the last cycle of every digit slot drives
// all lines off so the previous digit cannot ghost into the next one. The text
// and cursor inputs are snapshotted once per frame so a frame never tears.
// The character input is named str because "string" is a SystemVerilog keyword.
module string_display #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] str,
  input  logic [4:0]  count_8,
  input  logic [3:0]  mode,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int DW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [DW-1:0] d_reg;
  logic [2:0]    idx_reg;
  logic [BW-1:0] bc_reg;
  logic          ph_reg;
  logic [31:0]   sh_str_reg;
  logic [4:0]    sh_cnt_reg;
  logic [3:0]    sh_mode_reg;
  logic [4:0]    cnt_prev_reg;
  logic [3:0]    mode_prev_reg;
  logic [7:0]    an_reg;
  logic [7:0]    seg_reg;
  logic [7:0]    an_next;
  logic [7:0]    seg_next;

  logic          scan_wrap;
  logic          blink_wrap;
  logic          restart;
  logic          cursor;
  logic [3:0]    nibble;
  logic [6:0]    glyph;

  // Per-digit views of the shadow text and the active-low one-hot enable.
  logic [3:0] nib [8];
  logic [7:0] an_sel [8];
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      assign nib[gi]    = sh_str_reg[4*gi +: 4];
      assign an_sel[gi] = ~(8'd1 << gi);
    end
  endgenerate

  // Event detection: slot end, blink half-period end, cursor move / edit entry.
  always_comb begin
    scan_wrap  = (d_reg == DW'(SCAN_DIV - 1));
    blink_wrap = (bc_reg == BW'(BLINK_DIV - 1));
    restart    = (count_8 != cnt_prev_reg) ||
                 ((mode_prev_reg == 4'd0) && (mode != 4'd0));
    nibble     = nib[idx_reg];
    cursor     = (sh_mode_reg != 4'd0) && (sh_cnt_reg <= 5'd7) &&
                 (sh_cnt_reg[2:0] == idx_reg);
  end

  // Hex glyph table, active low, bit order g..a.
  always_comb begin
    glyph = 7'h7F;
    case (nibble)
      4'h0: glyph = ~7'h3F;
      4'h1: glyph = ~7'h06;
      4'h2: glyph = ~7'h5B;
      4'h3: glyph = ~7'h4F;
      4'h4: glyph = ~7'h66;
      4'h5: glyph = ~7'h6D;
      4'h6: glyph = ~7'h7D;
      4'h7: glyph = ~7'h07;
      4'h8: glyph = ~7'h7F;
      4'h9: glyph = ~7'h6F;
      4'hA: glyph = ~7'h77;
      4'hB: glyph = ~7'h7C;
      4'hC: glyph = ~7'h39;
      4'hD: glyph = ~7'h5E;
      4'hE: glyph = ~7'h79;
      4'hF: glyph = ~7'h71;
      default: glyph = 7'h7F;
    endcase
  end

  // Next output value: guard slot blanks everything, cursor digit lights dp and blinks.
  always_comb begin
    an_next  = 8'hFF;
    seg_next = 8'hFF;
    if (!scan_wrap) begin
      an_next = an_sel[idx_reg];
      if (cursor) begin
        seg_next = {1'b0, (ph_reg ? glyph : 7'h7F)};
      end else begin
        seg_next = {1'b1, glyph};
      end
    end
  end

  // Scan prescaler and digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_reg   <= '0;
      idx_reg <= 3'd0;
    end else if (scan_wrap) begin
      d_reg   <= '0;
      idx_reg <= idx_reg + 3'd1;
    end else begin
      d_reg   <= d_reg + DW'(1);
    end
  end

  // Blink counter; a restart beats a simultaneous wrap so a moved cursor shows at once.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      bc_reg <= '0;
      ph_reg <= 1'b1;
    end else if (blink_wrap) begin
      bc_reg <= '0;
      ph_reg <= ~ph_reg;
    end else begin
      bc_reg <= bc_reg + BW'(1);
    end
  end

  // Previous live cursor/mode; tracked through reset so release causes no spurious restart.
  always_ff @(posedge clk) begin
    cnt_prev_reg  <= count_8;
    mode_prev_reg <= mode;
  end

  // Frame snapshot taken in the guard slot of digit 7.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_str_reg  <= 32'd0;
      sh_cnt_reg  <= 5'd0;
      sh_mode_reg <= 4'd0;
    end else if (scan_wrap && (idx_reg == 3'd7)) begin
      sh_str_reg  <= str;
      sh_cnt_reg  <= count_8;
      sh_mode_reg <= mode;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_reg  <= 8'hFF;
      seg_reg <= 8'hFF;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;

endmodule

// File: tb/tb_string_display.sv
// tb_string_display: random and directed stimulus against a time-based
// reference model; expected outputs go into a queue, a monitor compares.
module tb_string_display;

  localparam int S = 4;
  localparam int B = 16;

  // Standard hex glyphs, active-high, bit order g..a.
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] str;
  logic [4:0]  count_8;
  logic [3:0]  mode;
  logic [7:0]  an;
  logic [7:0]  seg;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: cycles since reset release, cycle at which blink last restarted.
  int          cyc = 0;
  int          rst_base = 0;
  logic [31:0] m_str = 32'd0;
  int          m_cnt = 0;
  int          m_mode = 0;
  logic [4:0]  prev_cnt = 5'd0;
  logic [3:0]  prev_mode = 4'd0;

  always #5 clk = ~clk;

  string_display #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .clk     (clk),
    .reset   (reset),
    .str     (str),
    .count_8 (count_8),
    .mode    (mode),
    .an      (an),
    .seg     (seg)
  );

  // Reference model: digit position and blink phase follow from elapsed time.
  initial begin
    exp_t       e;
    int         d;
    int         idx;
    bit         ph;
    logic [3:0] code;
    logic [6:0] g;
    forever begin
      @(posedge clk);
      if (reset) begin
        e.an = 8'hFF; e.seg = 8'hFF; e.cyc = -1;
        q.push_back(e);
        cyc = 0; rst_base = 0;
        m_str = 32'd0; m_cnt = 0; m_mode = 0;
      end else begin
        d   = cyc % S;
        idx = (cyc / S) % 8;
        ph  = (((cyc - rst_base) / B) % 2) == 0;
        e.cyc = cyc;
        if (d == S - 1) begin
          e.an = 8'hFF; e.seg = 8'hFF;
        end else begin
          e.an = ~(8'd1 << idx);
          code = 4'((m_str >> (4 * idx)) & 32'hF);
          g = ~HEX[code];
          if (m_mode != 0 && m_cnt <= 7 && m_cnt == idx)
            e.seg = {1'b0, (ph ? g : 7'h7F)};
          else
            e.seg = {1'b1, g};
        end
        q.push_back(e);
        if ((count_8 != prev_cnt) || (prev_mode == 4'd0 && mode != 4'd0))
          rst_base = cyc + 1;
        if (d == S - 1 && idx == 7) begin
          m_str = str; m_cnt = int'(count_8); m_mode = int'(mode);
        end
        cyc++;
      end
      prev_cnt  = count_8;
      prev_mode = mode;
    end
  end

  // Monitor: outputs are registered, so compare on the falling edge after each push.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (an !== e.an || seg !== e.seg) begin
          n_bad++;
          $display("FAIL an_seg t=%0t cyc=%0d: got an=%h seg=%h, expected an=%h seg=%h",
                   $time, e.cyc, an, seg, e.an, e.seg);
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) until the next edge will see the given digit index and prescaler value.
  task automatic wait_slot(input int want_idx, input int want_d);
    int k;
    for (k = 0; k < 200; k++) begin
      if (!reset && (cyc / S) % 8 == want_idx && cyc % S == want_d) break;
      @(negedge clk);
    end
    if (k == 200) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_slot: idx=%0d d=%0d not reached, expected within 200 cycles", want_idx, want_d);
    end
  endtask

  initial begin
    int k;
    reset = 1'b1; str = 32'h76543210; count_8 = 5'd0; mode = 4'd0;
    run(3);
    reset = 1'b0;
    $display("phase reset+run: string=76543210 mode=0");
    run(64);

    wait_slot(3, 0);
    str = 32'hFFFFFFFF;
    $display("phase tear: string->FFFFFFFF at idx 3");
    run(64);

    str = 32'h76543210; mode = 4'd1; count_8 = 5'd2;
    $display("phase cursor: mode=1 count_8=2");
    run(160);

    for (k = 0; k < 100; k++) begin
      if ((((cyc - rst_base) / B) % 2) == 1) break;
      @(negedge clk);
    end
    count_8 = 5'd5;
    $display("phase move: count_8 2->5 during blank");
    run(160);

    count_8 = 5'd9;
    $display("phase no-cursor: count_8=9");
    run(100);

    count_8 = 5'd3; str = 32'hA1B2C3D4;
    run(40);
    wait_slot(5, 2);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    $display("phase mid-frame reset at idx 5 d 2");
    run(64);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        $display("phase random %0d: reset pulse", i);
      end else begin
        str     = $urandom;
        count_8 = 5'($urandom_range(0, 10));
        mode    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        $display("phase random %0d: string=%h count_8=%0d mode=%0d", i, str, count_8, mode);
      end
      run($urandom_range(5, 120));
    end

    run(3);
    n_cmp++;
    if (q.size() > 1) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending, expected at most 1", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
